// File: rtl/seq_alu_core.sv
// seq_alu_core: WIDTH-bit sequential ALU between CPU decode and register write-back.
// One operation in flight; valid/ready handshakes on operand and result sides.
// Single-cycle ADD/SUB/AND/OR/XOR/COMP. MUL (shift-add) and DIV (restoring) iterate
// one bit per cycle.
//
// Build option: define SEQ_ALU_MULDIV_EN to include the iterative multiplier/divider.
// Without it, MUL and DIV complete in one cycle with all-zero results (zero=1).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   in_valid/ready  operand handshake (in_ready high only in IDLE)
//   a, b, opcode    operands and 3-bit opcode
//   out_valid/ready result handshake (outputs held while waiting for out_ready)
//   result          sum/diff/logic/MUL low/DIV quotient/COMP code
//   result_hi       MUL high half / DIV remainder, else 0
//   carry_out       ADD carry / SUB borrow, else 0
//   zero            result and result_hi both zero
//   div_zero        DIV with b==0
module seq_alu_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             zero,
    output logic             div_zero
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_COMP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
`ifdef SEQ_ALU_MULDIV_EN
        ,
        S_ITER = 2'd1
`endif
    } state_e;

    state_e state_q, state_d;

    logic             in_ready_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_hi_d;
    logic             carry_d;
    logic             zero_d;
    logic             div_zero_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;

`ifdef SEQ_ALU_MULDIV_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);

    // hi_q/lo_q: MUL product halves, or DIV partial remainder / quotient-dividend shifter
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            div_zero  <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            is_div_q  <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            result    <= result_d;
            result_hi <= result_hi_d;
            carry_out <= carry_d;
            zero      <= zero_d;
            div_zero  <= div_zero_d;
`ifdef SEQ_ALU_MULDIV_EN
            is_div_q  <= is_div_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        result_d    = result;
        result_hi_d = result_hi;
        carry_d     = carry_out;
        zero_d      = zero;
        div_zero_d  = div_zero;

        add_sum  = {1'b0, a} + {1'b0, b};
        // Top bit of the extended difference is the unsigned borrow (a < b)
        sub_diff = {1'b0, a} - {1'b0, b};

`ifdef SEQ_ALU_MULDIV_EN
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;

        // One shift-add multiply step: add multiplicand on b's LSB, shift product right
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        // One restoring divide step: shift next dividend bit into remainder, try subtract
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                hi_nx = div_diff[WIDTH-1:0];
                lo_nx = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = div_shift[WIDTH-1:0];
                lo_nx = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    result_d    = '0;
                    result_hi_d = '0;
                    carry_d     = 1'b0;
                    div_zero_d  = 1'b0;
                    case (opcode)
                        OP_ADD: begin
                            result_d = add_sum[WIDTH-1:0];
                            carry_d  = add_sum[WIDTH];
                        end
                        OP_SUB: begin
                            result_d = sub_diff[WIDTH-1:0];
                            carry_d  = sub_diff[WIDTH];
                        end
                        OP_AND: result_d = a & b;
                        OP_OR:  result_d = a | b;
                        OP_XOR: result_d = a ^ b;
                        OP_COMP: result_d = {{(WIDTH-3){1'b0}}, (a > b), (a == b), (a < b)};
`ifdef SEQ_ALU_MULDIV_EN
                        OP_MUL: begin
                            state_d     = S_ITER;
                            out_valid_d = 1'b0;
                            is_div_d    = 1'b0;
                            opnd_d      = a;
                            hi_d        = '0;
                            lo_d        = b;
                            cnt_d       = '0;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                result_d    = '1;
                                result_hi_d = a;
                                div_zero_d  = 1'b1;
                            end else begin
                                state_d     = S_ITER;
                                out_valid_d = 1'b0;
                                is_div_d    = 1'b1;
                                opnd_d      = b;
                                hi_d        = '0;
                                lo_d        = a;
                                cnt_d       = '0;
                            end
                        end
`else
                        OP_MUL, OP_DIV: result_d = '0;
`endif
                        default: result_d = '0;
                    endcase
                    zero_d = (state_d == S_DONE) && (result_d == '0) && (result_hi_d == '0);
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            S_ITER: begin
                hi_d  = hi_nx;
                lo_d  = lo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    result_d    = lo_nx;
                    result_hi_d = hi_nx;
                    carry_d     = 1'b0;
                    div_zero_d  = 1'b0;
                    zero_d      = (lo_nx == '0) && (hi_nx == '0);
                end
            end
`endif
            S_DONE: begin
                // Results stay frozen until the consumer takes them, then clear
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    result_d    = '0;
                    result_hi_d = '0;
                    carry_d     = 1'b0;
                    zero_d      = 1'b0;
                    div_zero_d  = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: directed vector table, hand-written handshake/reset sequences and
// randomized operations checked against an arithmetic reference model.
// Follows SEQ_ALU_MULDIV_EN the same way as the design build.
module tb_seq_alu_core;

    localparam int unsigned WIDTH = 8;
    localparam int          MAXLAT = 100;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_COMP = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       opcode = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry_out;
    logic             zero;
    logic             div_zero;

    always #5 clk = ~clk;

    seq_alu_core #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry_out (carry_out),
        .zero      (zero),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] hi;
        logic             c;
        logic             z;
        logic             dz;
        int               lat;
    } obs_t;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        obs_t             exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model straight from the arithmetic definition of each opcode
    function automatic obs_t ref_op(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y);
        obs_t r;
        longint unsigned ia = longint'(x);
        longint unsigned ib = longint'(y);
        longint unsigned m  = (longint'(1) << WIDTH) - 1;
        longint unsigned p;
        r.res = '0; r.hi = '0; r.c = 1'b0; r.dz = 1'b0; r.lat = 1;
        case (op)
            OP_ADD:  begin p = ia + ib; r.res = WIDTH'(p & m); r.c = (p > m); end
            OP_SUB:  begin r.res = WIDTH'((ia - ib) & m); r.c = (ia < ib); end
            OP_AND:  r.res = x & y;
            OP_OR:   r.res = x | y;
            OP_XOR:  r.res = x ^ y;
            OP_COMP: r.res = WIDTH'({ia > ib, ia == ib, ia < ib});
`ifdef SEQ_ALU_MULDIV_EN
            OP_MUL: begin
                p = ia * ib;
                r.res = WIDTH'(p & m);
                r.hi  = WIDTH'(p >> WIDTH);
                r.lat = WIDTH + 1;
            end
            OP_DIV: begin
                if (ib == 0) begin
                    r.res = '1; r.hi = x; r.dz = 1'b1;
                end else begin
                    r.res = WIDTH'(ia / ib);
                    r.hi  = WIDTH'(ia % ib);
                    r.lat = WIDTH + 1;
                end
            end
`endif
            default: r.res = '0;
        endcase
        r.z = (r.res == '0) && (r.hi == '0);
        return r;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_tests++;
        if (got.res !== exp.res || got.hi !== exp.hi || got.c !== exp.c ||
            got.z !== exp.z || got.dz !== exp.dz || got.lat != exp.lat) begin
            n_fail++;
            $display("FAIL %s: got res=%h hi=%h c=%b z=%b dz=%b lat=%0d, expected res=%h hi=%h c=%b z=%b dz=%b lat=%0d",
                     name, got.res, got.hi, got.c, got.z, got.dz, got.lat,
                     exp.res, exp.hi, exp.c, exp.z, exp.dz, exp.lat);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (in_ready !== 1'b1 && guard < MAXLAT) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= MAXLAT) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_in_ready: timed out after %0d cycles", guard);
        end
    endtask

    // Issue one operation, measure latency, capture results, hold, then drain
    task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input int hold, output obs_t o);
        wait_ready();
        in_valid = 1'b1; opcode = op; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        opcode = 3'($urandom);
        o.lat = 1;
        while (out_valid !== 1'b1 && o.lat < MAXLAT) begin
            @(posedge clk); #1;
            o.lat++;
        end
        o.res = result; o.hi = result_hi; o.c = carry_out; o.z = zero; o.dz = div_zero;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t tbl[14];
    obs_t got;
    obs_t exp;

    initial begin
        tbl[0]  = '{OP_ADD,  8'h05, 8'h03, '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[1]  = '{OP_SUB,  8'hCC, 8'hAA, '{8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[2]  = '{OP_AND,  8'hCC, 8'hAA, '{8'h88, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[3]  = '{OP_OR,   8'hCC, 8'hAA, '{8'hEE, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[4]  = '{OP_XOR,  8'hCC, 8'hAA, '{8'h66, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[5]  = '{OP_COMP, 8'hCC, 8'hAA, '{8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[6]  = '{OP_ADD,  8'hFF, 8'h01, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1}};
        tbl[7]  = '{OP_SUB,  8'h05, 8'h07, '{8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1}};
        tbl[8]  = '{OP_COMP, 8'h03, 8'h03, '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[9]  = '{OP_COMP, 8'h01, 8'h09, '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
        tbl[10] = '{OP_MUL,  8'hCC, 8'hAA, '{8'h78, 8'h87, 1'b0, 1'b0, 1'b0, 9}};
        tbl[11] = '{OP_DIV,  8'h05, 8'h03, '{8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 9}};
        tbl[12] = '{OP_DIV,  8'h05, 8'h00, '{8'hFF, 8'h05, 1'b0, 1'b0, 1'b1, 1}};
        tbl[13] = '{OP_DIV,  8'h00, 8'h05, '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_outputs_zero", (result == '0) && (result_hi == '0) && !carry_out
                  && !zero && !div_zero, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_bit("in_ready_after_reset", in_ready, 1'b1);
        check_bit("out_valid_after_reset", out_valid, 1'b0);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            exp = tbl[i].exp;
`ifndef SEQ_ALU_MULDIV_EN
            if (tbl[i].op == OP_MUL || tbl[i].op == OP_DIV)
                exp = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
`endif
            run_op(tbl[i].op, tbl[i].va, tbl[i].vb, i % 3, got);
            check_obs($sformatf("vec%0d_op%0d", i, tbl[i].op), got, exp);
        end

        // Outputs frozen in DONE while out_ready is low; in_valid ignored
        wait_ready();
        in_valid = 1'b1; opcode = OP_XOR; a = 8'hCC; b = 8'hAA;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            opcode = OP_ADD; a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(posedge clk); #1;
            check_bit($sformatf("hold_cycle%0d", i),
                      out_valid && (result == 8'h66) && (result_hi == 8'h00) && !zero
                      && !carry_out && !in_ready, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_bit("hold_release_idle", in_ready && !out_valid, 1'b1);
        @(posedge clk); #1;
        check_bit("hold_no_stray_accept", out_valid, 1'b0);

        // out_ready while idle has no effect
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op(OP_OR, 8'h0F, 8'h30, 0, got);
        check_obs("or_after_idle_ready", got, ref_op(OP_OR, 8'h0F, 8'h30));

        // Asynchronous reset in the middle of a MUL
        wait_ready();
        in_valid = 1'b1; opcode = OP_MUL; a = 8'hCC; b = 8'hAA;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_bit("midop_reset_clears", !out_valid && (result == '0) && (result_hi == '0)
                  && !carry_out && !zero && !div_zero, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_bit("midop_reset_ready", in_ready && !out_valid, 1'b1);
        run_op(OP_ADD, 8'h05, 8'h03, 0, got);
        check_obs("add_after_reset", got, '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1});

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [2:0]       rop;
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            rop = 3'($urandom_range(0, 7));
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            if ($urandom_range(0, 9) == 0) rb = '0;
            run_op(rop, ra, rb, $urandom_range(0, 3), got);
            check_obs($sformatf("rand%0d_op%0d_a%h_b%h", i, rop, ra, rb), got, ref_op(rop, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
